// File: rtl/dc_err_store.sv
// Splits chroma DC diffusion error into left/top shares, keeps the left share in a
// register and the top share per macroblock column in a line RAM with a registered read port.
module dc_err_store #(
    parameter int MB_COLS = 1024,
    parameter int ADDR_W  = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] x,
    input  logic [47:0]       derr,
    input  logic              top_derr_en,
    input  logic [ADDR_W-1:0] top_derr_addr,
    output logic [31:0]       top_derr,
    output logic [31:0]       left_derr,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {IDLE, CALC, WRITE, DONE} state_t;

    localparam logic [ADDR_W:0] MB_LIM = MB_COLS[ADDR_W:0];

    state_t            state_q;
    logic [47:0]       derr_q;
    logic [ADDR_W-1:0] x_q;
    logic [31:0]       left_w_q;
    logic [31:0]       top_w_q;
    logic [31:0]       left_q;
    logic [31:0]       top_derr_q;
    logic              busy_q;
    logic              done_q;
    logic              ram_we;
    logic [31:0]       ram_q [MB_COLS];
    logic [31:0]       split_u;
    logic [31:0]       split_v;

    // Returns {top1, top0, left1, left0}; left1 = floor(3*err3/4) fits int8, so bits [9:2] suffice.
    function automatic logic [31:0] split_ch(input logic [23:0] e);
        logic signed [9:0] e3;
        logic signed [9:0] t3;
        logic [7:0]        l1;
        e3 = 10'($signed(e[23:16]));
        t3 = e3 + (e3 <<< 1);
        l1 = t3[9:2];
        return {8'(e[23:16] - l1), e[15:8], l1, e[7:0]};
    endfunction

    assign split_u = split_ch(derr_q[23:0]);
    assign split_v = split_ch(derr_q[47:24]);

    // Handshake: start is a one-cycle request honoured only in IDLE; busy covers CALC/WRITE,
    // done pulses once when the RAM write and left_derr update have taken effect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            derr_q   <= '0;
            x_q      <= '0;
            left_w_q <= '0;
            top_w_q  <= '0;
            left_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        derr_q  <= derr;
                        x_q     <= x;
                        busy_q  <= 1'b1;
                        state_q <= CALC;
                    end
                end
                CALC: begin
                    left_w_q <= {split_v[15:0], split_u[15:0]};
                    top_w_q  <= {split_v[31:16], split_u[31:16]};
                    state_q  <= WRITE;
                end
                WRITE: begin
                    left_q  <= left_w_q;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= DONE;
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ram_we = (state_q == WRITE) && ({1'b0, x_q} < MB_LIM);

    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram_q[x_q] <= top_w_q;
        end
    end

    // Write-first bypass so a same-cycle read of the column being written sees the new word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            top_derr_q <= '0;
        end else if (top_derr_en) begin
            if (ram_we && (top_derr_addr == x_q)) begin
                top_derr_q <= top_w_q;
            end else begin
                top_derr_q <= ram_q[top_derr_addr];
            end
        end
    end

    assign top_derr  = top_derr_q;
    assign left_derr = left_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_dc_err_store.sv
// Directed bench for dc_err_store: table of hand-computed vectors plus multi-cycle corner sequences.
module tb_dc_err_store;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [9:0]  x;
  logic [47:0] derr;
  logic        top_derr_en;
  logic [9:0]  top_derr_addr;
  logic [31:0] top_derr;
  logic [31:0] left_derr;
  logic        busy;
  logic        done;

  int checks;
  int failures;

  typedef struct {
    logic [47:0] derr;
    logic [9:0]  x;
    logic [31:0] left;
    logic [31:0] top;
  } vec_t;

  vec_t vecs[5];
  logic [31:0] exp_q[$];

  dc_err_store #(.MB_COLS(1024), .ADDR_W(10)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .x             (x),
    .derr          (derr),
    .top_derr_en   (top_derr_en),
    .top_derr_addr (top_derr_addr),
    .top_derr      (top_derr),
    .left_derr     (left_derr),
    .busy          (busy),
    .done          (done)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // driver tasks
  task automatic do_store(input logic [47:0] d, input logic [9:0] xa, output int lat);
    @(negedge clk);
    derr  = d;
    x     = xa;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 0;
    while (lat < 10) begin
      @(negedge clk);
      lat++;
      if (lat == 1) check("busy_in_calc", {31'd0, busy}, 32'd1);
      if (done) break;
    end
  endtask

  task automatic read_word(input logic [9:0] addr, output logic [31:0] data);
    @(negedge clk);
    top_derr_en   = 1'b1;
    top_derr_addr = addr;
    @(posedge clk);
    #1 top_derr_en = 1'b0;
    @(negedge clk);
    data = top_derr;
  endtask

  initial begin
    int          lat;
    int          ndone;
    logic [31:0] rd;
    logic [31:0] exp;

    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    start = 1'b0;
    x = '0;
    derr = '0;
    top_derr_en = 1'b0;
    top_derr_addr = '0;

    // U err3=-1, V err3=-128
    vecs[0] = '{48'h800000FF0000, 10'd0, 32'hA000FF00, 32'hE0000000};
    // U err3=127, V err3=4
    vecs[1] = '{48'h0420107F0201, 10'd1, 32'h03105F01, 32'h01202002};
    // U err3=-2, V err3=1
    vecs[2] = '{48'h0100FFFE7F80, 10'd2, 32'h00FFFE80, 32'h0100007F};
    // reference example U: 5,-3,8  V: -4,7,-7
    vecs[3] = '{48'hF907FC08FD05, 10'd3, 32'hFAFC0605, 32'hFF0702FD};
    // U err3=-128, V err3=127
    vecs[4] = '{48'h7FFF0080807F, 10'd4, 32'h5F00A07F, 32'h20FFE080};

    repeat (3) @(negedge clk);
    check("reset_left", left_derr, 32'h0);
    check("reset_top", top_derr, 32'h0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    rst_n = 1'b1;

    // back-to-back stores to columns 0..4
    for (int i = 0; i < 5; i++) begin
      do_store(vecs[i].derr, vecs[i].x, lat);
      check("store_latency", lat, 32'd3);
      check("store_left", left_derr, vecs[i].left);
      exp_q.push_back(vecs[i].top);
    end
    check("last_left", left_derr, vecs[4].left);
    for (int i = 0; i < 5; i++) begin
      read_word(10'(i), rd);
      exp = exp_q.pop_front();
      check("readback_top", rd, exp);
    end

    // read data holds while enable is low
    top_derr_addr = 10'd0;
    repeat (3) @(negedge clk);
    check("top_hold", top_derr, vecs[4].top);

    // start re-pulsed through CALC and WRITE is ignored
    @(negedge clk);
    derr = vecs[0].derr;
    x = 10'd5;
    start = 1'b1;
    @(posedge clk);
    #1 derr = vecs[3].derr;
    x = 10'd0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1 start = 1'b0;
    ndone = 0;
    repeat (6) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("repulse_done_count", ndone, 32'd1);
    check("repulse_left", left_derr, vecs[0].left);
    read_word(10'd5, rd);
    check("repulse_top5", rd, vecs[0].top);
    read_word(10'd0, rd);
    check("repulse_top0", rd, vecs[0].top);

    // write-first collision on column 3
    @(negedge clk);
    derr = vecs[4].derr;
    x = 10'd3;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    #1 top_derr_en = 1'b1;
    top_derr_addr = 10'd3;
    @(posedge clk);
    #1 top_derr_en = 1'b0;
    @(negedge clk);
    check("collision_top", top_derr, vecs[4].top);
    read_word(10'd3, rd);
    check("collision_ram", rd, vecs[4].top);

    // last column and done pulse width
    do_store(vecs[1].derr, 10'd1023, lat);
    check("col1023_latency", lat, 32'd3);
    check("col1023_left", left_derr, vecs[1].left);
    @(negedge clk);
    check("done_one_cycle", {31'd0, done}, 32'd0);
    read_word(10'd1023, rd);
    check("col1023_top", rd, vecs[1].top);

    // reset asserted during WRITE
    @(negedge clk);
    derr = vecs[1].derr;
    x = 10'd2;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("rst_write_left", left_derr, 32'h0);
    check("rst_write_top", top_derr, 32'h0);
    check("rst_write_busy", {31'd0, busy}, 32'd0);
    check("rst_write_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    repeat (5) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("rst_write_no_done", ndone, 32'd0);
    read_word(10'd2, rd);
    check("rst_write_ram_kept", rd, vecs[2].top);
    do_store(vecs[3].derr, 10'd6, lat);
    check("post_rst_latency", lat, 32'd3);
    check("post_rst_left", left_derr, vecs[3].left);
    read_word(10'd6, rd);
    check("post_rst_top", rd, vecs[3].top);

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule
